// File: rtl/sync_fifo_ctrl_if.sv
// Handshake and status bundle for sync_fifo_ctrl.
// The master side drives requests and data. The slave side (the FIFO) returns data and status.
interface sync_fifo_ctrl_if #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 256
);
  localparam int AW = $clog2(DEPTH);

  logic              flush;
  logic              clr_err;
  logic              wr_en;
  logic [DWIDTH-1:0] din;
  logic              rd_en;
  logic [DWIDTH-1:0] dout;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic [AW:0]       count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, clr_err, wr_en, din, rd_en,
    input  dout, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  flush, clr_err, wr_en, din, rd_en,
    output dout, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with occupancy flags, sticky error flags and flush.
// The read path is either standard (registered dout) or first-word-fall-through.
module sync_fifo_ctrl #(
  parameter int DWIDTH   = 8,
  parameter int DEPTH    = 256,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input logic            clk,
  input logic            rst,
  sync_fifo_ctrl_if.slave bus
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0] AF_C    = AF_LEVEL[AW:0];
  localparam logic [AW:0] AE_C    = AE_LEVEL[AW:0];
  localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic              r_overflow;
  logic              r_underflow;
  logic [AW:0]       w_count;
  logic              w_empty;
  logic              w_full;
  logic              w_rd_acc;
  logic              w_wr_acc;

  // Occupancy comes from the pointer difference; the extra wrap bit tells full apart from empty.
  assign w_count  = r_wptr - r_rptr;
  assign w_empty  = (w_count == {(AW+1){1'b0}});
  assign w_full   = (w_count == DEPTH_C);
  assign w_rd_acc = bus.rd_en & ~w_empty;
  assign w_wr_acc = bus.wr_en & (~w_full | w_rd_acc);

  assign bus.count        = w_count;
  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.almost_empty = (w_count <= AE_C);
  assign bus.almost_full  = (w_count >= AF_C);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

  // Storage write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush && w_wr_acc) begin
      r_mem[r_wptr[AW-1:0]] <= bus.din;
    end
  end

  // Pointer update: reset, then flush, then accepted transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= {(AW+1){1'b0}};
      r_rptr <= {(AW+1){1'b0}};
    end else if (bus.flush) begin
      r_wptr <= {(AW+1){1'b0}};
      r_rptr <= {(AW+1){1'b0}};
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + ONE_C;
      if (w_rd_acc) r_rptr <= r_rptr + ONE_C;
    end
  end

  // Sticky error flags; a new error wins over clr_err in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (!bus.flush) begin
      if (bus.wr_en && !w_wr_acc) r_overflow <= 1'b1;
      else if (bus.clr_err)       r_overflow <= 1'b0;
      if (bus.rd_en && w_empty)   r_underflow <= 1'b1;
      else if (bus.clr_err)       r_underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.dout = r_mem[r_rptr[AW-1:0]];
    end else begin : g_std
      logic [DWIDTH-1:0] r_dout;

      // Registered read data; holds on rejected reads and through flush.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_dout <= {DWIDTH{1'b0}};
        end else if (!bus.flush && w_rd_acc) begin
          r_dout <= r_mem[r_rptr[AW-1:0]];
        end
      end

      assign bus.dout = r_dout;
    end
  endgenerate
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: standard and FWFT instances share one stimulus stream.
// Both are checked against a queue-based model, plus directed literal checks.
module tb_sync_fifo_ctrl;
  localparam int DW = 8, DEPTH = 16, AF = 12, AE = 2;

  logic       clk = 1'b0;
  logic       rst, flush, clr_err, wr_en, rd_en;
  logic [7:0] din;

  sync_fifo_ctrl_if #(.DWIDTH(DW), .DEPTH(DEPTH)) if0 ();
  sync_fifo_ctrl_if #(.DWIDTH(DW), .DEPTH(DEPTH)) if1 ();

  assign if0.flush = flush;  assign if1.flush = flush;
  assign if0.clr_err = clr_err;  assign if1.clr_err = clr_err;
  assign if0.wr_en = wr_en;  assign if1.wr_en = wr_en;
  assign if0.rd_en = rd_en;  assign if1.rd_en = rd_en;
  assign if0.din = din;  assign if1.din = din;

  sync_fifo_ctrl #(.DWIDTH(DW), .DEPTH(DEPTH), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE))
    u_std (.clk(clk), .rst(rst), .bus(if0.slave));
  sync_fifo_ctrl #(.DWIDTH(DW), .DEPTH(DEPTH), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE))
    u_fwft (.clk(clk), .rst(rst), .bus(if1.slave));

  always #5 clk = ~clk;

  logic [7:0] q[$];
  logic [7:0] m_dout;
  bit         m_ov, m_un;
  bit         chk_en = 1'b0;
  int         tests = 0, fails = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The model updates from the inputs that were present at the edge that just passed.
  task automatic model_update();
    bit was_empty, ra, wa;
    if (rst) begin
      q.delete(); m_ov = 1'b0; m_un = 1'b0; m_dout = 8'h00;
    end else if (flush) begin
      q.delete();
    end else begin
      was_empty = (q.size() == 0);
      ra = rd_en && !was_empty;
      wa = wr_en && (q.size() < DEPTH || ra);
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(din);
      if (wr_en && !wa) m_ov = 1'b1; else if (clr_err) m_ov = 1'b0;
      if (rd_en && was_empty) m_un = 1'b1; else if (clr_err) m_un = 1'b0;
    end
  endtask

  task automatic step(bit r, bit fl, bit ce, bit we, bit re, logic [7:0] d);
    rst = r; flush = fl; clr_err = ce; wr_en = we; rd_en = re; din = d;
    @(posedge clk); #1;
    model_update();
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 32'(if0.count), 32'(q.size()));
      chk("empty", 32'(if0.empty), 32'(q.size() == 0));
      chk("full", 32'(if0.full), 32'(q.size() == DEPTH));
      chk("almost_empty", 32'(if0.almost_empty), 32'(q.size() <= AE));
      chk("almost_full", 32'(if0.almost_full), 32'(q.size() >= AF));
      chk("overflow", 32'(if0.overflow), 32'(m_ov));
      chk("underflow", 32'(if0.underflow), 32'(m_un));
      chk("std dout", 32'(if0.dout), 32'(m_dout));
      chk("fwft count", 32'(if1.count), 32'(q.size()));
      chk("fwft empty", 32'(if1.empty), 32'(q.size() == 0));
      chk("fwft overflow", 32'(if1.overflow), 32'(m_ov));
      chk("fwft underflow", 32'(if1.underflow), 32'(m_un));
      if (q.size() != 0) chk("fwft dout", 32'(if1.dout), 32'(q[0]));
    end
  end

  initial begin
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk_en = 1'b1;
    chk("rst count", 32'(if0.count), 32'd0);
    chk("rst empty", 32'(if0.empty), 32'd1);
    chk("rst almost_empty", 32'(if0.almost_empty), 32'd1);
    chk("rst almost_full", 32'(if0.almost_full), 32'd0);
    chk("rst dout", 32'(if0.dout), 32'd0);

    // Fill to full, then one rejected write.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'(i));
      if (i == 10) chk("af at 11", 32'(if0.almost_full), 32'd0);
      if (i == 11) chk("af at 12", 32'(if0.almost_full), 32'd1);
    end
    chk("fill full", 32'(if0.full), 32'd1);
    chk("fill count", 32'(if0.count), 32'd16);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hEE);
    chk("ovf set", 32'(if0.overflow), 32'd1);
    chk("ovf count", 32'(if0.count), 32'd16);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("clr ovf", 32'(if0.overflow), 32'd0);

    // Drain in order, then read on empty.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("drain dout", 32'(if0.dout), 32'(i));
    end
    chk("drain empty", 32'(if0.empty), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("unf set", 32'(if0.underflow), 32'd1);
    chk("unf dout hold", 32'(if0.dout), 32'h0F);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    // Read+write on empty: write only.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55);
    chk("rw empty unf", 32'(if0.underflow), 32'd1);
    chk("rw empty count", 32'(if0.count), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    chk("rw empty data", 32'(if0.dout), 32'h55);

    // Read+write on full: both accepted.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA);
    chk("rw full dout", 32'(if0.dout), 32'h10);
    chk("rw full count", 32'(if0.count), 32'd16);
    chk("rw full ovf", 32'(if0.overflow), 32'd0);

    // Set-over-clear priority, then flush at count 9 with wr_en.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hBB);
    chk("set beats clr", 32'(if0.overflow), 32'd1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("pre flush count", 32'(if0.count), 32'd9);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hCC);
    chk("flush count", 32'(if0.count), 32'd0);
    chk("flush empty", 32'(if0.empty), 32'd1);
    chk("flush ovf kept", 32'(if0.overflow), 32'd1);
    chk("flush dout kept", 32'(if0.dout), 32'h17);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("clr_err", 32'(if0.overflow), 32'd0);

    // Wrap with steady occupancy of 5.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'(8'h45 + i));
    chk("wrap count", 32'(if0.count), 32'd5);
    chk("wrap dout", 32'(if0.dout), 32'h53);

    // FWFT single word, then reset mid-burst.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C);
    chk("fwft dout 3C", 32'(if1.dout), 32'h3C);
    chk("fwft not empty", 32'(if1.empty), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("fwft empty after rd", 32'(if1.empty), 32'd1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b1, i[0], 8'(8'h70 + i));
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF);
    chk("rst mid count", 32'(if0.count), 32'd0);
    chk("rst mid dout", 32'(if0.dout), 32'd0);

    // Randomised phases with shifting write/read bias.
    for (int ph = 0; ph < 6; ph++) begin
      int wp;
      wp = (ph % 3 == 0) ? 85 : ((ph % 3 == 1) ? 15 : 50);
      for (int n = 0; n < 120; n++) begin
        step(($urandom_range(0, 199) == 0),
             ($urandom_range(0, 99) == 0),
             ($urandom_range(0, 29) == 0),
             ($urandom_range(0, 99) < wp),
             ($urandom_range(0, 99) < 100 - wp),
             8'($urandom));
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
